// File: rtl/vram_arbiter.sv
// Single-port frame-buffer RAM arbiter: display reads have absolute priority, host writes use free slots.
// Optional macro WR_POST_EN adds a 4-entry posted-write FIFO between the host and the RAM.
module vram_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 12,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_stall,
    output logic              disp_ovf,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(2 * MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(2 * MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, RD, RD_WAIT, WR} state_t;

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pendAddr_q, pendAddr_d;
    logic              ovf_q, ovf_d;
    logic              ramEn_q, ramEn_d;
    logic              ramWe_q, ramWe_d;
    logic [ADDR_W-1:0] ramAddr_q, ramAddr_d;
    logic [DATA_W-1:0] ramWdata_q, ramWdata_d;
    logic [DATA_W-1:0] dispData_q, dispData_d;
    logic              dispValid_q, dispValid_d;
    logic              wrAck_q, wrAck_d;
    logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;

    logic              wrGo;
    logic [ADDR_W-1:0] wrSrcAddr;
    logic [DATA_W-1:0] wrSrcData;

`ifdef WR_POST_EN
    localparam int DEPTH = 4;

    logic [ADDR_W-1:0] fifoAddr_q [DEPTH];
    logic [DATA_W-1:0] fifoData_q [DEPTH];
    logic [1:0]        rdPtr_q, wrPtr_q;
    logic [2:0]        fifoCnt_q;
    logic              push, drain;

    // The host is acked as soon as there is room; the RAM side drains on its own schedule.
    assign push      = wr_req && !wrAck_q && (fifoCnt_q != 3'd4);
    assign drain     = (state_d == WR);
    assign wrGo      = (fifoCnt_q != 3'd0);
    assign wrSrcAddr = fifoAddr_q[rdPtr_q];
    assign wrSrcData = fifoData_q[rdPtr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q   <= 2'd0;
            wrPtr_q   <= 2'd0;
            fifoCnt_q <= 3'd0;
        end else begin
            if (push)
                wrPtr_q <= wrPtr_q + 2'd1;
            if (drain)
                rdPtr_q <= rdPtr_q + 2'd1;
            fifoCnt_q <= fifoCnt_q + {2'd0, push} - {2'd0, drain};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr_q[wrPtr_q] <= wr_addr;
            fifoData_q[wrPtr_q] <= wr_data;
        end
    end
`else
    // A held request is not re-taken in its own ack cycle, so each write is acked exactly once.
    assign wrGo      = wr_req && !wrAck_q;
    assign wrSrcAddr = wr_addr;
    assign wrSrcData = wr_data;
`endif

    always_comb begin
        state_d     = IDLE;
        pend_d      = pend_q;
        pendAddr_d  = pendAddr_q;
        ovf_d       = ovf_q;
        ramEn_d     = 1'b0;
        ramWe_d     = 1'b0;
        ramAddr_d   = ramAddr_q;
        ramWdata_d  = ramWdata_q;
        dispData_d  = dispData_q;
        dispValid_d = 1'b0;

        if (state_q == RD_WAIT) begin
            dispData_d  = ram_rdata;
            dispValid_d = 1'b1;
        end

        // Only one request can wait; anything beyond that is lost and flagged.
        if (disp_req && pend_q)
            ovf_d = 1'b1;

        if (state_q == RD) begin
            state_d = RD_WAIT;
            if (disp_req && !pend_q) begin
                pend_d     = 1'b1;
                pendAddr_d = disp_addr;
            end
        end else if (pend_q) begin
            state_d   = RD;
            ramEn_d   = 1'b1;
            ramAddr_d = pendAddr_q;
            pend_d    = 1'b0;
        end else if (disp_req) begin
            state_d   = RD;
            ramEn_d   = 1'b1;
            ramAddr_d = disp_addr;
        end else if (wrGo) begin
            state_d    = WR;
            ramEn_d    = 1'b1;
            ramWe_d    = 1'b1;
            ramAddr_d  = wrSrcAddr;
            ramWdata_d = wrSrcData;
        end

`ifdef WR_POST_EN
        wrAck_d = push;
`else
        wrAck_d = (state_d == WR);
`endif

        waitCnt_d = waitCnt_q;
        if (wrAck_q)
            waitCnt_d = '0;
        else if (wr_req && (waitCnt_q != CNT_SAT))
            waitCnt_d = waitCnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= 1'b0;
            pendAddr_q  <= '0;
            ovf_q       <= 1'b0;
            ramEn_q     <= 1'b0;
            ramWe_q     <= 1'b0;
            ramAddr_q   <= '0;
            ramWdata_q  <= '0;
            dispData_q  <= '0;
            dispValid_q <= 1'b0;
            wrAck_q     <= 1'b0;
            waitCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pendAddr_q  <= pendAddr_d;
            ovf_q       <= ovf_d;
            ramEn_q     <= ramEn_d;
            ramWe_q     <= ramWe_d;
            ramAddr_q   <= ramAddr_d;
            ramWdata_q  <= ramWdata_d;
            dispData_q  <= dispData_d;
            dispValid_q <= dispValid_d;
            wrAck_q     <= wrAck_d;
            waitCnt_q   <= waitCnt_d;
        end
    end

    assign disp_data  = dispData_q;
    assign disp_valid = dispValid_q;
    assign wr_ack     = wrAck_q;
    assign wr_stall   = (waitCnt_q > CNT_LIM);
    assign disp_ovf   = ovf_q;
    assign ram_en     = ramEn_q;
    assign ram_we     = ramWe_q;
    assign ram_addr   = ramAddr_q;
    assign ram_wdata  = ramWdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: random and directed traffic checked against a slot-level reference model.
// The read model schedules each display read at the first edge the RAM is free of earlier reads.
module tb_vram_arbiter;

    localparam int AW   = 19;
    localparam int DW   = 12;
    localparam int MAXW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [DW-1:0] disp_data;
    logic          disp_valid;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack, wr_stall, disp_ovf, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_stall(wr_stall), .disp_ovf(disp_ovf),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 12'hAAC;
    endfunction

    // Synchronous RAM: data appears the cycle after a read is enabled.
    always @(posedge clk)
        if (ram_en && !ram_we)
            ram_rdata <= pix(ram_addr);

    typedef struct {
        int            validEdge;
        int            sampleEdge;
        int            startEdge;
        logic [AW-1:0] addr;
    } rd_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    rd_t           rdQ[$];
    wr_t           wrQ[$];
    logic [AW-1:0] startAddr [int];
    int            edgeNo = 0;
    int            lastStart = -100;
    int            stallCnt = 0;
    bit            modelOvf = 0;
    bit            ackSeen = 0;
    logic [DW-1:0] expData = '0;
    logic [AW-1:0] hostAddr = '0;
    logic [DW-1:0] hostData = '0;
    int            nCompared = 0;
    int            nMismatched = 0;
    int            ackCount = 0;
    int            writesDone = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, expv, edgeNo);
        end
    endtask

    task automatic clearModel();
        rdQ.delete();
        wrQ.delete();
        startAddr.delete();
        lastStart = -100;
        stallCnt  = 0;
        modelOvf  = 0;
        ackSeen   = 0;
        expData   = '0;
    endtask

    task automatic checkAllZero(input string ph);
        checkOutput({ph, "_disp_data"}, disp_data, 0);
        checkOutput({ph, "_disp_valid"}, disp_valid, 0);
        checkOutput({ph, "_wr_ack"}, wr_ack, 0);
        checkOutput({ph, "_wr_stall"}, wr_stall, 0);
        checkOutput({ph, "_disp_ovf"}, disp_ovf, 0);
        checkOutput({ph, "_ram_en"}, ram_en, 0);
        checkOutput({ph, "_ram_we"}, ram_we, 0);
        checkOutput({ph, "_ram_addr"}, ram_addr, 0);
        checkOutput({ph, "_ram_wdata"}, ram_wdata, 0);
    endtask

    // Reset is asserted between edges to exercise its asynchronous path.
    task automatic doReset();
        #2;
        reset    = 1'b1;
        disp_req = 1'b0;
        wr_req   = 1'b0;
        #1;
        checkAllZero("rst");
        clearModel();
        @(posedge clk);
        #1;
        edgeNo++;
        checkAllZero("rst_hold");
        #1;
        reset = 1'b0;
    endtask

    task automatic newWrite();
        hostAddr = AW'($urandom) | 19'h40000;
        hostData = DW'($urandom);
    endtask

    task automatic startWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        hostAddr = a;
        hostData = d;
        wr_req   = 1'b1;
        wr_addr  = a;
        wr_data  = d;
    endtask

    task automatic applyStimulus(input bit rd, input logic [AW-1:0] ra, input bit wantW);
        int  t;
        int  s;
        bit  pendingNow;
        rd_t e;
        if (ackSeen) begin
            if (wantW) begin
                newWrite();
                wr_req = 1'b1;
            end else begin
                wr_req = 1'b0;
            end
        end else if (!wr_req && wantW) begin
            newWrite();
            wr_req = 1'b1;
        end
        wr_addr   = hostAddr;
        wr_data   = hostData;
        disp_req  = rd;
        disp_addr = ra;

        t = edgeNo + 1;
        if (rd) begin
            pendingNow = 0;
            foreach (rdQ[i])
                if (rdQ[i].sampleEdge < t && rdQ[i].startEdge >= t)
                    pendingNow = 1;
            if (pendingNow) begin
                modelOvf = 1;
            end else begin
                s = (t > lastStart + 2) ? t : lastStart + 2;
                lastStart = s;
                e.validEdge  = s + 2;
                e.sampleEdge = t;
                e.startEdge  = s;
                e.addr       = ra;
                rdQ.push_back(e);
                startAddr[s] = ra;
            end
        end
        if (ackSeen)
            stallCnt = 0;
        else if (wr_req && stallCnt < 2 * MAXW)
            stallCnt++;

        @(posedge clk);
        #1;
        edgeNo++;

        checkOutput("disp_ovf", disp_ovf, modelOvf);
        checkOutput("wr_stall", wr_stall, stallCnt > MAXW);
        if (rdQ.size() > 0 && rdQ[0].validEdge == edgeNo) begin
            expData = pix(rdQ[0].addr);
            checkOutput("disp_valid", disp_valid, 1);
            void'(rdQ.pop_front());
        end else begin
            checkOutput("disp_valid", disp_valid, 0);
        end
        checkOutput("disp_data", disp_data, expData);
        if (startAddr.exists(edgeNo)) begin
            checkOutput("ram_read", ram_en && !ram_we, 1);
            checkOutput("ram_rd_addr", ram_addr, startAddr[edgeNo]);
            startAddr.delete(edgeNo);
        end else begin
            checkOutput("ram_read", ram_en && !ram_we, 0);
        end

        ackSeen = wr_ack;
        if (wr_ack) begin
            ackCount++;
            wrQ.push_back('{a: hostAddr, d: hostData});
`ifndef WR_POST_EN
            checkOutput("ack_with_write", ram_we, 1);
`endif
        end
        if (ram_we) begin
            writesDone++;
            checkOutput("we_with_en", ram_en, 1);
            if (wrQ.size() == 0) begin
                checkOutput("write_expected", ram_we, 0);
            end else begin
                checkOutput("wr_addr", ram_addr, wrQ[0].a);
                checkOutput("wr_data", ram_wdata, wrQ[0].d);
                void'(wrQ.pop_front());
            end
        end
    endtask

    initial begin
        int t0;
        int ackE;
        int valE;
        int firstStall;
        int w0;
        int a0;

        // Single read after reset.
        doReset();
        applyStimulus(1, 19'h00010, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, '0, 0);
        checkOutput("t1_data", disp_data, 12'hABC);

        // Single write with an idle display.
        startWrite(19'h12345, 12'h5A5);
        applyStimulus(0, '0, 0);
`ifdef WR_POST_EN
        checkOutput("t2_ack", wr_ack, 1);
        applyStimulus(0, '0, 0);
`else
        checkOutput("t2_ack", wr_ack, 1);
`endif
        checkOutput("t2_we", ram_we, 1);
        checkOutput("t2_addr", ram_addr, 19'h12345);
        checkOutput("t2_wdata", ram_wdata, 12'h5A5);
        checkOutput("t2_stall", wr_stall, 0);
        applyStimulus(0, '0, 0);
        checkOutput("t2_ack_once", wr_ack, 0);

        // Read and write in the same cycle: the read goes first.
        doReset();
        startWrite(19'h40400, 12'h3C3);
        applyStimulus(1, 19'h00020, 0);
        t0 = edgeNo;
        checkOutput("t3_rd_first", ram_we, 0);
        ackE = -1;
        valE = -1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, '0, 0);
            if (wr_ack && ackE < 0) ackE = edgeNo;
            if (disp_valid && valE < 0) valE = edgeNo;
        end
        checkOutput("t3_valid_lat", valE - t0, 2);
`ifndef WR_POST_EN
        checkOutput("t3_ack_lat", ackE - t0, 2);
`endif

        // Pixel-rate reads with the host writing continuously.
        doReset();
        w0 = writesDone;
        for (int i = 0; i < 2560; i++)
            applyStimulus((i % 4) == 0, AW'($urandom) & 19'h3FFFF, 1);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, '0, 0);
        checkOutput("t4_ovf", disp_ovf, 0);
        checkOutput("t4_writes_interleaved", (writesDone - w0) >= 600, 1);

        // Overflow is sticky; then reset lands in the middle of a read.
        doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 19'h00005 + AW'(i), 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, '0, 0);
        checkOutput("t5_ovf_sticky", disp_ovf, 1);
        applyStimulus(1, 19'h00077, 0);
        doReset();
        for (int i = 0; i < 6; i++)
            applyStimulus(0, '0, 0);

`ifndef WR_POST_EN
        // Host starved by back-to-back reads.
        doReset();
        startWrite(19'h40abc, 12'h123);
        t0 = edgeNo + 1;
        firstStall = -1;
        for (int i = 0; i < 22; i++) begin
            applyStimulus((i % 2) == 0, AW'($urandom) & 19'h3FFFF, 0);
            if (wr_stall && firstStall < 0) firstStall = edgeNo - t0 + 1;
        end
        for (int i = 0; i < 6; i++)
            applyStimulus(0, '0, 0);
        checkOutput("t6_stall_edge", firstStall, 17);
        checkOutput("t6_stall_clear", wr_stall, 0);
`else
        // Posted writes: four are absorbed while reads hog the RAM, the fifth waits for a drain.
        doReset();
        a0 = ackCount;
        for (int i = 0; i < 16; i++)
            applyStimulus((i % 2) == 0, AW'($urandom) & 19'h3FFFF, 1);
        checkOutput("post_acks_full", ackCount - a0, 4);
        a0 = ackCount;
        for (int i = 0; i < 3; i++)
            applyStimulus(0, '0, 1);
        checkOutput("post_ack_after_drain", ackCount - a0 >= 1, 1);
        for (int i = 0; i < 12; i++)
            applyStimulus(0, '0, 0);
        checkOutput("post_drained", wrQ.size(), 0);
`endif

        // Random mix of reads and writes.
        doReset();
        for (int i = 0; i < 3000; i++)
            applyStimulus($urandom_range(0, 3) == 0, AW'($urandom) & 19'h3FFFF, $urandom_range(0, 1) == 1);
        for (int i = 0; i < 12; i++)
            applyStimulus(0, '0, 0);
        checkOutput("end_wr_queue", wrQ.size(), 0);
        checkOutput("end_rd_queue", rdQ.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
